serial_detect_sched: RTL and testbench
======================================

SERIAL_DETECT_SCHED -- requirements
Module: serial_detect_sched

Interface
REQ-001 SHALL have parameters: DATA_W, default 8, word width serialized per grant; PAT_W, default 5, pattern/window width.
REQ-002 SHALL have ports: clk_i  in  1  sole clock, rising edge.
REQ-003 rst_i  in  1  reset, asynchronous, active-high.
REQ-004 req0_valid_i / req1_valid_i  in  1  requester 0/1 word available.
REQ-005 req0_data_i / req1_data_i  in  DATA_W  requester 0/1 word, serialized MSB first.
REQ-006 req0_ready_o / req1_ready_o  out  1  word accepted this cycle when valid&ready.
REQ-007 pattern_i  in  PAT_W  bit pattern to detect, sampled at handshake.
REQ-008 cnt_clr_i  in  1  synchronous clear of match_cnt_o.
REQ-009 match_o  out  1  one-cycle pulse per pattern hit.
REQ-010 match_src_o  out  1  requester owning current/last word.
REQ-011 match_cnt_o  out  8  saturating hit count.
REQ-012 busy_o  out  1  high in SHIFT or DONE.
REQ-013 state_o  out  3  one-hot state: IDLE=001, SHIFT=010, DONE=100.

Function
REQ-014 FSM SHALL have states IDLE, SHIFT, DONE; any other state_o value SHALL go to IDLE next cycle.
REQ-015 In IDLE, exactly one ready SHALL be high when at least one valid is high: the sole valid requester, or if both valid, the one not granted last (round-robin); no ready outside IDLE.
REQ-016 ready_o SHALL be combinational from state, valids and last-grant register; both readys low in IDLE when no valid.
REQ-017 On handshake: latch data into shift register, latch pattern_i, set match_src_o to winner, update last-grant, clear history and bit counter, enter SHIFT.
REQ-018 Each SHIFT cycle: history <= {history[PAT_W-2:0], shreg MSB}; shreg shifts left; counter +1.
REQ-019 match_o SHALL be registered, high the cycle after the shift for which updated counter >= PAT_W and updated history == latched pattern; overlapping matches SHALL all count.
REQ-020 History SHALL NOT carry across words; no match spans two words.
REQ-021 SHIFT lasts exactly DATA_W cycles, then DONE for exactly 1 cycle, then IDLE; minimum handshake-to-handshake spacing DATA_W+2 cycles (10 at default).
REQ-022 match_cnt_o SHALL increment on each match_o pulse, saturate at 255, and go to 0 on cnt_clr_i; clear SHALL win over a simultaneous increment.
REQ-023 pattern_i or valid/data changes after handshake SHALL NOT affect the word in progress.
REQ-024 Valid deasserted without handshake SHALL be legal; no state change.

Reset
REQ-025 While rst_i high, asynchronously: state IDLE (state_o=001), match_o=0, match_cnt_o=0, match_src_o=0, busy_o=0, history/shreg/counter=0, last-grant=1 (requester 0 wins first tie).
REQ-026 Reset mid-SHIFT SHALL abandon the word with no match_o pulse; first post-reset handshake SHALL follow REQ-015.

Verification
REQ-027 pattern 10110, req0 sends 8'b10110110 -> req0_ready_o=1 one cycle, match_o pulses after shifts 5 and 8, match_cnt_o=2, match_src_o=0.
REQ-028 Both valid continuously after reset -> grants 0,1,0,1 alternate, handshakes 10 cycles apart, busy_o high 9 cycles each.
REQ-029 pattern 11111, data 8'hFF -> 4 match_o pulses (shifts 5-8); next word 8'h07 with pattern 11111 -> 0 pulses (no cross-word window).
REQ-030 Preload count to 254, word producing 3 hits -> match_cnt_o 255 and holds; cnt_clr_i coincident with a hit -> 0.
REQ-031 rst_i asserted at SHIFT cycle 3 -> outputs immediately at REQ-025 values, no match_o; after release req1 alone valid -> req1_ready_o=1.
REQ-032 Change pattern_i and req data during SHIFT -> hits computed from latched values only.

Source files
------------

// File: rtl/serial_detect_sched.sv
// serial_detect_sched
//   Two requesters offer DATA_W-bit words. A round-robin arbiter grants one
//   word at a time. The granted word is shifted out MSB first, and a PAT_W-bit
//   sliding window is compared against the pattern captured at the handshake.
//   Each hit produces a one-cycle match pulse and bumps a saturating counter.
//
// Ports
//   clk_i, rst_i                 clock (rising edge), async active-high reset
//   req0_valid_i, req1_valid_i   requester word available
//   req0_data_i,  req1_data_i    requester word (DATA_W bits)
//   req0_ready_o, req1_ready_o   grant; a word is taken when valid & ready
//   pattern_i                    pattern to detect, captured at the handshake
//   cnt_clr_i                    synchronous clear of match_cnt_o
//   match_o                      one-cycle pulse per pattern hit
//   match_src_o                  requester that owns the current/last word
//   match_cnt_o                  saturating hit count
//   busy_o                       high while in SHIFT or DONE
//   state_o                      one-hot state (IDLE=001, SHIFT=010, DONE=100)

module serial_detect_sched #(
  parameter int DATA_W = 8,
  parameter int PAT_W  = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req0_valid_i,
  input  logic              req1_valid_i,
  input  logic [DATA_W-1:0] req0_data_i,
  input  logic [DATA_W-1:0] req1_data_i,
  output logic              req0_ready_o,
  output logic              req1_ready_o,
  input  logic [PAT_W-1:0]  pattern_i,
  input  logic              cnt_clr_i,
  output logic              match_o,
  output logic              match_src_o,
  output logic [7:0]        match_cnt_o,
  output logic              busy_o,
  output logic [2:0]        state_o
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'b001,
    SHIFT = 3'b010,
    DONE  = 3'b100
  } state_t;

  state_t             state;
  logic               last_grant;
  logic [DATA_W-1:0]  shreg;
  logic [PAT_W-1:0]   history;
  logic [PAT_W-1:0]   pat_q;
  logic [CNT_W-1:0]   bit_cnt;
  logic               match_q;
  logic               src_q;
  logic [7:0]         cnt_q;

  logic               grant0;
  logic               grant1;
  logic               hs0;
  logic               hs1;
  logic [CNT_W-1:0]   cnt_next;
  logic [PAT_W-1:0]   hist_next;

  // Arbiter: only in IDLE. On a tie the requester that did not win last time
  // gets the grant; last_grant resets to 1 so requester 0 wins the first tie.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE) begin
      if (req0_valid_i && req1_valid_i) begin
        if (last_grant) grant0 = 1'b1;
        else            grant1 = 1'b1;
      end else if (req0_valid_i) begin
        grant0 = 1'b1;
      end else if (req1_valid_i) begin
        grant1 = 1'b1;
      end
    end
  end

  assign req0_ready_o = grant0;
  assign req1_ready_o = grant1;
  assign hs0          = req0_valid_i & grant0;
  assign hs1          = req1_valid_i & grant1;

  // Values the window and bit counter take after the current shift; the match
  // decision is made on these so the pulse lands one cycle after the shift.
  assign cnt_next  = bit_cnt + CNT_W'(1);
  assign hist_next = {history[PAT_W-2:0], shreg[DATA_W-1]};

  // Main FSM. History is cleared at every handshake so no window ever spans
  // two words. Unknown (non one-hot) states fall back to IDLE.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      shreg      <= '0;
      history    <= '0;
      pat_q      <= '0;
      bit_cnt    <= '0;
      match_q    <= 1'b0;
      src_q      <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      match_q <= 1'b0;
      case (state)
        IDLE: begin
          if (hs0 || hs1) begin
            shreg      <= hs1 ? req1_data_i : req0_data_i;
            pat_q      <= pattern_i;
            src_q      <= hs1;
            last_grant <= hs1;
            history    <= '0;
            bit_cnt    <= '0;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          history <= hist_next;
          shreg   <= {shreg[DATA_W-2:0], 1'b0};
          bit_cnt <= cnt_next;
          match_q <= (cnt_next >= CNT_W'(PAT_W)) && (hist_next == pat_q);
          if (cnt_next == CNT_W'(DATA_W)) state <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Hit counter: clear has priority over a coincident increment; saturates.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (cnt_clr_i) begin
      cnt_q <= '0;
    end else if (match_q && (cnt_q != 8'hFF)) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign match_o     = match_q;
  assign match_src_o = src_q;
  assign match_cnt_o = cnt_q;
  assign busy_o      = (state == SHIFT) || (state == DONE);
  assign state_o     = state;

endmodule

// File: tb/tb_serial_detect_sched.sv
// tb_serial_detect_sched
//   Directed bench for serial_detect_sched. Inputs are driven and outputs are
//   sampled around the falling clock edge. Expected values are hand-computed.

module tb_serial_detect_sched;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       req0_valid_i = 1'b0;
  logic       req1_valid_i = 1'b0;
  logic [7:0] req0_data_i = '0;
  logic [7:0] req1_data_i = '0;
  logic       req0_ready_o;
  logic       req1_ready_o;
  logic [4:0] pattern_i = '0;
  logic       cnt_clr_i = 1'b0;
  logic       match_o;
  logic       match_src_o;
  logic [7:0] match_cnt_o;
  logic       busy_o;
  logic [2:0] state_o;

  int n_cmp  = 0;
  int n_fail = 0;

  serial_detect_sched #(.DATA_W(8), .PAT_W(5)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req0_valid_i (req0_valid_i),
    .req1_valid_i (req1_valid_i),
    .req0_data_i  (req0_data_i),
    .req1_data_i  (req1_data_i),
    .req0_ready_o (req0_ready_o),
    .req1_ready_o (req1_ready_o),
    .pattern_i    (pattern_i),
    .cnt_clr_i    (cnt_clr_i),
    .match_o      (match_o),
    .match_src_o  (match_src_o),
    .match_cnt_o  (match_cnt_o),
    .busy_o       (busy_o),
    .state_o      (state_o)
  );

  always #5 clk_i = ~clk_i;

  // Hard stop so a stuck run still reports.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Offer one word from requester src starting at a falling edge, then watch
  // the 10 following falling edges. mask[i] = match_o at falling edge i+1
  // after the handshake. At iteration clr_iter cnt_clr_i is raised for one
  // cycle; cnt_snap holds match_cnt_o one iteration later.
  task automatic do_word(input bit src, input logic [7:0] d, input logic [4:0] p,
                         input bit scramble, input int clr_iter,
                         output logic [9:0] mask, output logic [7:0] cnt_snap,
                         output logic rdy_other, output logic rdy_after);
    int waited;
    mask = '0; cnt_snap = '0; rdy_other = 1'b0; rdy_after = 1'b0;
    if (src) begin req1_valid_i = 1'b1; req1_data_i = d; end
    else     begin req0_valid_i = 1'b1; req0_data_i = d; end
    pattern_i = p;
    #1;
    waited = 0;
    while (!(src ? req1_ready_o : req0_ready_o) && waited < 20) begin
      @(negedge clk_i); #1;
      waited++;
    end
    n_cmp++;
    if (!(src ? req1_ready_o : req0_ready_o)) begin
      n_fail++;
      $display("[TB] FAIL grant_wait: ready=0 after %0d cycles, required 1", waited);
      req0_valid_i = 1'b0; req1_valid_i = 1'b0;
      return;
    end
    rdy_other = src ? req0_ready_o : req1_ready_o;
    @(posedge clk_i);
    @(negedge clk_i);
    rdy_after = src ? req1_ready_o : req0_ready_o;
    req0_valid_i = 1'b0; req1_valid_i = 1'b0;
    if (scramble) begin
      pattern_i   = ~p;
      req0_data_i = ~d;
      req1_data_i = ~d;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      if (match_o) mask[i] = 1'b1;
      if (i == clr_iter + 1) cnt_snap = match_cnt_o;
      cnt_clr_i = (i == clr_iter);
    end
    cnt_clr_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    req0_valid_i = 1'b1; req1_valid_i = 1'b1;
    repeat (2) @(negedge clk_i);
    #1;
    n_cmp++; if (state_o !== 3'b001) begin n_fail++; $display("[TB] FAIL reset_state: got %b want 001", state_o); end
    n_cmp++; if ({match_o, match_src_o, busy_o} !== 3'b000) begin n_fail++; $display("[TB] FAIL reset_flags: got %b want 000", {match_o, match_src_o, busy_o}); end
    n_cmp++; if (match_cnt_o !== 8'd0) begin n_fail++; $display("[TB] FAIL reset_cnt: got %0d want 0", match_cnt_o); end
    req0_valid_i = 1'b0; req1_valid_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    n_cmp++; if ({req0_ready_o, req1_ready_o} !== 2'b00) begin n_fail++; $display("[TB] FAIL idle_no_valid_ready: got %b want 00", {req0_ready_o, req1_ready_o}); end
  endtask

  task automatic test_valid_drop();
    @(negedge clk_i);
    req1_valid_i = 1'b1; req1_data_i = 8'hA5;
    #1;
    n_cmp++; if ({req0_ready_o, req1_ready_o} !== 2'b01) begin n_fail++; $display("[TB] FAIL sole_valid_ready: got %b want 01", {req0_ready_o, req1_ready_o}); end
    #2 req1_valid_i = 1'b0;
    @(negedge clk_i); #1;
    n_cmp++; if ({state_o, busy_o} !== 4'b0010) begin n_fail++; $display("[TB] FAIL valid_drop_state: got %b want 0010", {state_o, busy_o}); end
    req0_valid_i = 1'b1; req1_valid_i = 1'b1;
    #1;
    n_cmp++; if ({req0_ready_o, req1_ready_o} !== 2'b10) begin n_fail++; $display("[TB] FAIL first_tie_ready: got %b want 10", {req0_ready_o, req1_ready_o}); end
    #1 begin req0_valid_i = 1'b0; req1_valid_i = 1'b0; end
    @(negedge clk_i);
  endtask

  task automatic test_basic();
    logic [9:0] mask; logic [7:0] snap; logic ro, ra;
    do_word(1'b0, 8'b10110110, 5'b10110, 1'b0, -1, mask, snap, ro, ra);
    n_cmp++; if (ro !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_other_ready: got %b want 0", ro); end
    n_cmp++; if (ra !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_ready_one_cycle: got %b want 0", ra); end
    n_cmp++; if (mask !== 10'h090) begin n_fail++; $display("[TB] FAIL basic_match_pos: got %h want 090", mask); end
    n_cmp++; if (match_cnt_o !== 8'd2) begin n_fail++; $display("[TB] FAIL basic_cnt: got %0d want 2", match_cnt_o); end
    n_cmp++; if (match_src_o !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_src: got %b want 0", match_src_o); end
  endtask

  task automatic test_back_to_back();
    int gcyc[$]; int gsrc[$]; int busy_cnt;
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    req0_data_i = 8'h00; req1_data_i = 8'h00; pattern_i = 5'b11111;
    req0_valid_i = 1'b1; req1_valid_i = 1'b1;
    busy_cnt = 0;
    for (int c = 0; c < 45; c++) begin
      #1;
      if (req0_ready_o) begin gcyc.push_back(c); gsrc.push_back(0); end
      if (req1_ready_o) begin gcyc.push_back(c); gsrc.push_back(1); end
      if (busy_o && c >= 1 && c <= 9) busy_cnt++;
      @(negedge clk_i);
    end
    req0_valid_i = 1'b0; req1_valid_i = 1'b0;
    n_cmp++;
    if (gcyc.size() < 4) begin
      n_fail++; $display("[TB] FAIL b2b_grant_count: got %0d want >=4", gcyc.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_cmp++; if (gsrc[k] != (k % 2)) begin n_fail++; $display("[TB] FAIL b2b_grant_src[%0d]: got %0d want %0d", k, gsrc[k], k % 2); end
        n_cmp++; if (gcyc[k] != 10 * k) begin n_fail++; $display("[TB] FAIL b2b_grant_cycle[%0d]: got %0d want %0d", k, gcyc[k], 10 * k); end
      end
    end
    n_cmp++; if (busy_cnt != 9) begin n_fail++; $display("[TB] FAIL b2b_busy_cycles: got %0d want 9", busy_cnt); end
    n_cmp++; if (match_cnt_o !== 8'd0) begin n_fail++; $display("[TB] FAIL b2b_no_hits: got %0d want 0", match_cnt_o); end
  endtask

  task automatic test_all_ones();
    logic [9:0] mask; logic [7:0] snap; logic ro, ra;
    cnt_clr_i = 1'b1;
    do_word(1'b0, 8'hFF, 5'b11111, 1'b0, -1, mask, snap, ro, ra);
    n_cmp++; if (mask !== 10'h0F0) begin n_fail++; $display("[TB] FAIL ones_match_pos: got %h want 0f0", mask); end
    do_word(1'b0, 8'h07, 5'b11111, 1'b0, -1, mask, snap, ro, ra);
    n_cmp++; if (mask !== 10'h000) begin n_fail++; $display("[TB] FAIL no_cross_word: got %h want 000", mask); end
    n_cmp++; if (match_cnt_o !== 8'd4) begin n_fail++; $display("[TB] FAIL ones_cnt: got %0d want 4", match_cnt_o); end
  endtask

  task automatic test_latched();
    logic [9:0] mask; logic [7:0] snap; logic ro, ra;
    do_word(1'b1, 8'b10110110, 5'b10110, 1'b1, -1, mask, snap, ro, ra);
    n_cmp++; if (mask !== 10'h090) begin n_fail++; $display("[TB] FAIL latched_match_pos: got %h want 090", mask); end
    n_cmp++; if (match_src_o !== 1'b1) begin n_fail++; $display("[TB] FAIL latched_src: got %b want 1", match_src_o); end
    n_cmp++; if (match_cnt_o !== 8'd6) begin n_fail++; $display("[TB] FAIL latched_cnt: got %0d want 6", match_cnt_o); end
  endtask

  task automatic test_reset_mid_shift();
    int hits;
    req1_valid_i = 1'b1; req1_data_i = 8'hFF; pattern_i = 5'b11111;
    #1;
    n_cmp++; if (req1_ready_o !== 1'b1) begin n_fail++; $display("[TB] FAIL rms_grant: got %b want 1", req1_ready_o); end
    @(posedge clk_i);
    @(negedge clk_i);
    req1_valid_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    n_cmp++; if (state_o !== 3'b001) begin n_fail++; $display("[TB] FAIL rms_state: got %b want 001", state_o); end
    n_cmp++; if ({match_o, match_src_o, busy_o} !== 3'b000) begin n_fail++; $display("[TB] FAIL rms_flags: got %b want 000", {match_o, match_src_o, busy_o}); end
    n_cmp++; if (match_cnt_o !== 8'd0) begin n_fail++; $display("[TB] FAIL rms_cnt: got %0d want 0", match_cnt_o); end
    hits = 0;
    repeat (2) begin @(negedge clk_i); if (match_o) hits++; end
    rst_i = 1'b0;
    repeat (10) begin @(negedge clk_i); if (match_o) hits++; end
    n_cmp++; if (hits != 0) begin n_fail++; $display("[TB] FAIL rms_no_match: got %0d pulses want 0", hits); end
    req1_valid_i = 1'b1;
    #1;
    n_cmp++; if ({req0_ready_o, req1_ready_o} !== 2'b01) begin n_fail++; $display("[TB] FAIL rms_post_grant: got %b want 01", {req0_ready_o, req1_ready_o}); end
    @(posedge clk_i);
    @(negedge clk_i);
    req1_valid_i = 1'b0;
    repeat (10) @(negedge clk_i);
  endtask

  task automatic test_saturate();
    logic [9:0] mask; logic [7:0] snap; logic ro, ra;
    cnt_clr_i = 1'b1;
    @(negedge clk_i);
    cnt_clr_i = 1'b0;
    for (int w = 0; w < 63; w++) do_word(1'b0, 8'hFF, 5'b11111, 1'b0, -1, mask, snap, ro, ra);
    do_word(1'b0, 8'b10110110, 5'b10110, 1'b0, -1, mask, snap, ro, ra);
    n_cmp++; if (match_cnt_o !== 8'd254) begin n_fail++; $display("[TB] FAIL sat_preload: got %0d want 254", match_cnt_o); end
    do_word(1'b1, 8'b01111111, 5'b11111, 1'b0, -1, mask, snap, ro, ra);
    n_cmp++; if (mask !== 10'h0E0) begin n_fail++; $display("[TB] FAIL sat_three_hits: got %h want 0e0", mask); end
    n_cmp++; if (match_cnt_o !== 8'd255) begin n_fail++; $display("[TB] FAIL sat_reach: got %0d want 255", match_cnt_o); end
    do_word(1'b0, 8'hFF, 5'b11111, 1'b0, -1, mask, snap, ro, ra);
    n_cmp++; if (match_cnt_o !== 8'd255) begin n_fail++; $display("[TB] FAIL sat_hold: got %0d want 255", match_cnt_o); end
    do_word(1'b1, 8'hFF, 5'b11111, 1'b0, 4, mask, snap, ro, ra);
    n_cmp++; if (snap !== 8'd0) begin n_fail++; $display("[TB] FAIL clr_beats_hit: got %0d want 0", snap); end
    n_cmp++; if (match_cnt_o !== 8'd3) begin n_fail++; $display("[TB] FAIL cnt_after_clr: got %0d want 3", match_cnt_o); end
  endtask

  initial begin
    test_reset();
    test_valid_drop();
    test_basic();
    test_back_to_back();
    test_all_ones();
    test_latched();
    test_reset_mid_shift();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
